// File: rtl/alu_pkg.sv
// Shared widths, instruction field positions and ALU opcodes for alu_decode.
// Purely declarative: no latency, no flow control.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 16;
  localparam int REG_N   = 16;
  localparam int REG_AW  = 4;
  localparam int OP_W    = 3;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_ASHR = 3'd6,
    OP_ROTL = 3'd7
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } dec_state_e;

  // Opcode MSB marks the reserved half of the opcode space.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB];
  endfunction

  function automatic logic wb_hit(input logic              en,
                                  input logic [REG_AW-1:0] waddr,
                                  input logic [REG_AW-1:0] raddr);
    return en && (waddr != '0) && (waddr == raddr);
  endfunction

endpackage

// File: rtl/alu_decode_if.sv
// Instruction-in, writeback and decoded-operation-out bus of alu_decode.
// Valid/ready on both instruction and operation sides; writeback is a plain strobe.
interface alu_decode_if;
  import alu_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_W-1:0]       in_instr;
  logic                     wb_en;
  logic [REG_AW-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_a;
  logic signed [DATA_W-1:0] out_b;
  logic [OP_W-1:0]          out_op;
  logic [REG_AW-1:0]        out_imm;
  logic [REG_AW-1:0]        out_rd;
  logic                     illegal;

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_imm, out_rd, illegal
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_imm, out_rd, illegal
  );

endinterface

// File: rtl/reg_file.sv
// 16x16 register file, two async read ports, one write port; R0 reads zero.
// Reads are combinational, writes land on the rising edge; no backpressure.
module reg_file
  import alu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [REG_N];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/alu_decode.sv
// Decode stage: single-entry register holding operands for the ALU; ALU_DECODE_FWD_EN adds writeback bypass.
// Latency 1 cycle accept->out_valid; in_ready = !out_valid || out_ready, illegal words are consumed.
module alu_decode
  import alu_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  alu_decode_if.slave bus
);

  dec_state_e        r_state;
  dec_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_load;
  logic              w_xfer_out;
  logic              w_stall;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_a_nxt;
  logic [DATA_W-1:0] w_b_nxt;

  logic              r_illegal;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [REG_AW-1:0] r_imm;
  logic [REG_AW-1:0] r_rd;

  assign w_rs1      = bus.in_instr[RS1_MSB:RS1_LSB];
  assign w_rs2      = bus.in_instr[RS2_MSB:RS2_LSB];
  assign bus.in_ready = (r_state == ST_EMPTY) || bus.out_ready;
  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_load     = w_accept && !is_illegal(bus.in_instr);
  assign w_xfer_out = (r_state == ST_FULL) && bus.out_ready;
  assign w_stall    = (r_state == ST_FULL) && !bus.out_ready;

  reg_file u_reg_file (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_addr),
    .i_wdata  (bus.wb_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_xfer_out && !w_load) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

`ifdef ALU_DECODE_FWD_EN
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;

  // Source indices are kept so a stalled operation can pick up late writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if (w_load) begin
      r_rs1 <= w_rs1;
      r_rs2 <= w_rs2;
    end
  end

  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    if (w_load) begin
      w_a_nxt = wb_hit(bus.wb_en, bus.wb_addr, w_rs1) ? bus.wb_data : w_rd1;
      w_b_nxt = wb_hit(bus.wb_en, bus.wb_addr, w_rs2) ? bus.wb_data : w_rd2;
    end else if (w_stall) begin
      if (wb_hit(bus.wb_en, bus.wb_addr, r_rs1)) w_a_nxt = bus.wb_data;
      if (wb_hit(bus.wb_en, bus.wb_addr, r_rs2)) w_b_nxt = bus.wb_data;
    end
  end
`else
  // Async reads see the register file before this edge's write.
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    if (w_load) begin
      w_a_nxt = w_rd1;
      w_b_nxt = w_rd2;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_illegal <= w_accept && is_illegal(bus.in_instr);
      if (w_load) begin
        r_op  <= bus.in_instr[OPC_MSB-1:OPC_LSB];
        r_imm <= bus.in_instr[RS2_MSB:RS2_LSB];
        r_rd  <= bus.in_instr[RD_MSB:RD_LSB];
      end
    end
  end

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_a     = r_a;
  assign bus.out_b     = r_b;
  assign bus.out_op    = r_op;
  assign bus.out_imm   = r_imm;
  assign bus.out_rd    = r_rd;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_decode.sv
// Directed bench for alu_decode: spec-level model checked every cycle plus literal spot checks.
module tb_alu_decode;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  alu_decode_if bus ();

  alu_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: architectural registers and the single held operation.
  logic [15:0] m_r [16];
  bit          m_full;
  bit          m_ill;
  bit          m_rdy;
  bit          m_acc;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [3:0]  m_imm, m_rd;
`ifdef ALU_DECODE_FWD_EN
  logic [3:0]  m_rs1, m_rs2;
  function automatic bit hit(input logic [3:0] idx);
    return bus.wb_en && bus.wb_addr != 4'd0 && bus.wb_addr == idx;
  endfunction
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_r[i]) m_r[i] = 16'h0;
      m_full = 0; m_ill = 0;
      m_a = 0; m_b = 0; m_op = 0; m_imm = 0; m_rd = 0;
`ifdef ALU_DECODE_FWD_EN
      m_rs1 = 0; m_rs2 = 0;
`endif
    end else begin
      m_rdy = !m_full || bus.out_ready;
      m_acc = bus.in_valid && m_rdy;
      m_ill = m_acc && bus.in_instr[15];
      if (m_acc && !bus.in_instr[15]) begin
        m_full = 1;
        m_op   = bus.in_instr[14:12];
        m_rd   = bus.in_instr[11:8];
        m_imm  = bus.in_instr[3:0];
        m_a    = m_r[bus.in_instr[7:4]];
        m_b    = m_r[bus.in_instr[3:0]];
`ifdef ALU_DECODE_FWD_EN
        m_rs1 = bus.in_instr[7:4];
        m_rs2 = bus.in_instr[3:0];
        if (hit(m_rs1)) m_a = bus.wb_data;
        if (hit(m_rs2)) m_b = bus.wb_data;
`endif
      end else if (m_full && bus.out_ready) begin
        m_full = 0;
      end
`ifdef ALU_DECODE_FWD_EN
      else if (m_full) begin
        if (hit(m_rs1)) m_a = bus.wb_data;
        if (hit(m_rs2)) m_b = bus.wb_data;
      end
`endif
      if (bus.wb_en && bus.wb_addr != 4'd0) m_r[bus.wb_addr] = bus.wb_data;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  {15'h0, bus.in_ready},  {15'h0, !m_full || bus.out_ready});
    chk("out_valid", {15'h0, bus.out_valid}, {15'h0, m_full});
    chk("illegal",   {15'h0, bus.illegal},   {15'h0, m_ill});
    chk("out_a",     bus.out_a,              m_a);
    chk("out_b",     bus.out_b,              m_b);
    chk("out_op",    {13'h0, bus.out_op},    {13'h0, m_op});
    chk("out_imm",   {12'h0, bus.out_imm},   {12'h0, m_imm});
    chk("out_rd",    {12'h0, bus.out_rd},    {12'h0, m_rd});
  end

  task automatic drive(input logic v, input logic [15:0] ins, input logic ordy,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] ins;
    logic        ordy;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl [9] = '{
    '{1'b1, 16'h5123, 1'b1, 1'b1, 4'd1,  16'hAAAA},
    '{1'b1, 16'h6211, 1'b1, 1'b0, 4'd0,  16'h0000},
    '{1'b1, 16'h7312, 1'b0, 1'b1, 4'd2,  16'h0F0F},
    '{1'b1, 16'h8000, 1'b0, 1'b0, 4'd0,  16'h0000},
    '{1'b1, 16'h8000, 1'b1, 1'b0, 4'd0,  16'h0000},
    '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000},
    '{1'b1, 16'h3F21, 1'b1, 1'b1, 4'd15, 16'h7777},
    '{1'b1, 16'h2EF2, 1'b1, 1'b0, 4'd0,  16'h0000},
    '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000}
  };

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(0, 16'h0, 0, 0, 4'd0, 16'h0);
    #2;
    chk("rst out_valid", {15'h0, bus.out_valid}, 16'h0);
    chk("rst out_a",     bus.out_a,              16'h0);
    chk("rst illegal",   {15'h0, bus.illegal},   16'h0);
    #10 rst_n = 1'b1;

    drive(0, 16'h0, 0, 1, 4'd3, 16'h1234); step();
    drive(0, 16'h0, 0, 1, 4'd4, 16'h0010); step();
    drive(1, 16'h1534, 0, 0, 4'd0, 16'h0); step();
    chk("sub out_valid", {15'h0, bus.out_valid}, 16'h1);
    chk("sub out_op",    {13'h0, bus.out_op},    16'h1);
    chk("sub out_a",     bus.out_a,              16'h1234);
    chk("sub out_b",     bus.out_b,              16'h0010);
    chk("sub out_rd",    {12'h0, bus.out_rd},    16'h5);

    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h2634, 0, 0, 4'd0, 16'h0);
      #1;
      chk("stall in_ready", {15'h0, bus.in_ready}, 16'h0);
      chk("stall out_a",    bus.out_a,             16'h1234);
      step();
    end
    drive(1, 16'h2634, 1, 0, 4'd0, 16'h0); step();
    chk("reload out_valid", {15'h0, bus.out_valid}, 16'h1);
    chk("reload out_op",    {13'h0, bus.out_op},    16'h2);
    chk("reload out_rd",    {12'h0, bus.out_rd},    16'h6);
    drive(0, 16'h0, 1, 0, 4'd0, 16'h0); step();
    chk("drain out_valid", {15'h0, bus.out_valid}, 16'h0);

    drive(1, 16'h8123, 1, 0, 4'd0, 16'h0);
    #1;
    chk("ill in_ready", {15'h0, bus.in_ready}, 16'h1);
    step();
    chk("ill pulse",     {15'h0, bus.illegal},   16'h1);
    chk("ill out_valid", {15'h0, bus.out_valid}, 16'h0);
    drive(0, 16'h0, 1, 0, 4'd0, 16'h0); step();
    chk("ill clear", {15'h0, bus.illegal}, 16'h0);

    drive(1, 16'h0730, 0, 1, 4'd3, 16'hBEEF); step();
`ifdef ALU_DECODE_FWD_EN
    chk("byp out_a", bus.out_a, 16'hBEEF);
`else
    chk("byp out_a", bus.out_a, 16'h1234);
`endif
    drive(0, 16'h0, 0, 1, 4'd3, 16'h5555); step();
`ifdef ALU_DECODE_FWD_EN
    chk("held out_a", bus.out_a, 16'h5555);
`else
    chk("held out_a", bus.out_a, 16'h1234);
`endif
    drive(0, 16'h0, 1, 0, 4'd0, 16'h0); step();

    drive(0, 16'h0, 1, 1, 4'd0, 16'hFFFF); step();
    drive(1, 16'h0800, 1, 0, 4'd0, 16'h0); step();
    chk("r0 out_a",  bus.out_a,           16'h0);
    chk("r0 out_rd", {12'h0, bus.out_rd}, 16'h8);

    drive(1, 16'h4935, 1, 0, 4'd0, 16'h0); step();
    chk("shl out_a",   bus.out_a,            16'h5555);
    chk("shl out_imm", {12'h0, bus.out_imm}, 16'h5);
    drive(0, 16'h0, 0, 0, 4'd0, 16'h0); step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", {15'h0, bus.out_valid}, 16'h0);
    chk("midrst out_a",     bus.out_a,              16'h0);
    chk("midrst out_op",    {13'h0, bus.out_op},    16'h0);
    drive(0, 16'h0, 1, 0, 4'd0, 16'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post rst out_valid", {15'h0, bus.out_valid}, 16'h0);
    end
    drive(1, 16'h0A30, 1, 0, 4'd0, 16'h0); step();
    chk("post rst R3", bus.out_a, 16'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].ins, tbl[i].ordy, tbl[i].we, tbl[i].wa, tbl[i].wd);
      step();
    end
    drive(0, 16'h0, 1, 0, 4'd0, 16'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 The block SHALL have the following ports and parameters, clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream instruction word valid.
REQ-005 in_ready  output  1  block can accept in_instr this cycle.
REQ-006 in_instr  input  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm.
REQ-007 wb_en  input  1  writeback strobe from the stage after the ALU.
REQ-008 wb_addr  input  4  writeback register index.
REQ-009 wb_data  input  16  writeback value.
REQ-010 out_valid  output  1  decoded operation held for the ALU.
REQ-011 out_ready  input  1  ALU/downstream consumes the held operation this cycle.
REQ-012 out_a, out_b  output  16 each  signed operands to the ALU A and B inputs.
REQ-013 out_op  output  3  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 shl, 5 shr, 6 ashr, 7 rotl.
REQ-014 out_imm  output  4  shift/rotate amount (in_instr[3:0]).
REQ-015 out_rd  output  4  destination register, carried to writeback.
REQ-016 illegal  output  1  one-cycle pulse on an illegal opcode.

Function
REQ-017 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal !out_valid || out_ready (single-entry pipeline register, no combinational path from in_valid).
REQ-019 State machine: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on legal accept; FULL->EMPTY on transfer out without a legal accept; FULL->FULL on stall or on simultaneous transfer out plus legal accept.
REQ-020 Latency SHALL be exactly 1 cycle from accept to out_valid with decoded fields.
REQ-021 On legal accept: out_op=opcode[2:0], out_rd=[11:8], out_imm=[3:0], out_a=R[rs1], out_b=R[rs2].
REQ-022 Opcode[15]=1 SHALL be illegal: word accepted (consumed), not loaded, state unchanged, illegal=1 the next cycle.
REQ-023 Register file: 16 x 16 bit; R0 reads 0 always; writes to R0 ignored; other writes at clock edge when wb_en.
REQ-024 Outputs SHALL hold stable while out_valid && !out_ready, except for the bypass update in REQ-029.
REQ-025 out_* data fields in EMPTY SHALL keep their last values (don't-care for consumers).

Reset
REQ-026 On rst_n low, immediately: out_valid=0, illegal=0, out_a=out_b=0, out_op=0, out_imm=0, out_rd=0, all registers=0.
REQ-027 Reset mid-stall SHALL drop the held operation; no transfer out occurs for it after release.

Configuration
REQ-028 Macro ALU_DECODE_FWD_EN selects writeback bypassing.
REQ-029 Defined: a wb_en write to nonzero wb_addr matching rs1/rs2 in the accept cycle SHALL supply wb_data to out_a/out_b; while FULL and stalled, a matching write SHALL refresh the held operand (held rs1/rs2 stored).
REQ-030 Undefined: operands SHALL be the pre-write register values at accept and SHALL NOT change while held; no rs1/rs2 storage.

Structure
REQ-031 Package alu_pkg SHALL hold: opcode constants (OP_ADD..OP_ROTL), data width 16, register count 16, instruction field positions.
REQ-032 Sub-module reg_file (16x16, two async read ports, one write port, R0 zero) SHALL be instantiated once.

Verification
REQ-033 Reset, then wb R3=0x1234, R4=0x0010; instr 0x1534 (sub R5,R3,R4) -> next cycle out_valid=1, out_op=1, out_a=0x1234, out_b=0x0010, out_rd=5.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs constant; out_ready=1 -> one transfer, next instr loaded same edge.
REQ-035 Instr 0x8123 -> in_ready=1, illegal pulses 1 cycle, out_valid unchanged.
REQ-036 wb R3=0xBEEF in accept cycle of rs1=3 -> out_a=0xBEEF with ALU_DECODE_FWD_EN, old R3 without.
REQ-037 wb R0=0xFFFF then read rs1=0 -> out_a=0x0000.
REQ-038 rst_n low while FULL and stalled -> out_valid=0 immediately, no transfer after release.
